// File: rtl/tx_pend_sched.sv
// rtl/tx_pend_sched.sv - per-flow pending-bit tracker with round-robin TX dispatch scan
package tx_pend_sched_pkg;
  localparam logic [1:0] PEND_NOP   = 2'd0;
  localparam logic [1:0] PEND_SET   = 2'd1;
  localparam logic [1:0] PEND_CLEAR = 2'd2;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [15:0] timestamp;
  } pend_set_clear_t;

  typedef struct packed {
    logic [15:0]     flowid;
    pend_set_clear_t ack_pend_set_clear;
    pend_set_clear_t data_pend_set_clear;
    pend_set_clear_t rt_pend_set_clear;
  } sched_cmd_struct;
endpackage

module tx_pend_sched
  import tx_pend_sched_pkg::*;
#(
  parameter int MAX_FLOWS = 64,
  parameter int FLOWID_W  = $clog2(MAX_FLOWS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_val,
  input  sched_cmd_struct     cmd_data,
  output logic                cmd_rdy,
  output logic                sched_val,
  output logic [FLOWID_W-1:0] sched_flowid,
  output logic [2:0]          sched_flags,
  input  logic                sched_rdy
);

  typedef enum logic {SCAN, OUTPUT} state_t;

  state_t              state, state_next;
  logic [FLOWID_W-1:0] idx, idx_next;
  logic [2:0]          pend      [MAX_FLOWS];
  logic [2:0]          pend_next [MAX_FLOWS];
  logic [2:0]          cur;
  logic                latch;
  logic                accept;
  logic [FLOWID_W-1:0] cmd_flow;
  logic [FLOWID_W-1:0] flowid_q;
  logic [2:0]          flags_q;
  logic                unused_cmd;

  assign cmd_rdy      = ~rst;
  assign accept       = cmd_val & cmd_rdy;
  assign cmd_flow     = cmd_data.flowid[FLOWID_W-1:0];
  assign cur          = pend[idx];
  assign sched_val    = (state == OUTPUT);
  assign sched_flowid = flowid_q;
  assign sched_flags  = flags_q;
  assign unused_cmd   = ^{cmd_data.flowid,
                          cmd_data.ack_pend_set_clear.timestamp,
                          cmd_data.data_pend_set_clear.timestamp,
                          cmd_data.rt_pend_set_clear.timestamp};

  function automatic logic apply_op(input logic cur_bit, input logic [1:0] op);
    case (op)
      PEND_SET:   apply_op = 1'b1;
      PEND_CLEAR: apply_op = 1'b0;
      default:    apply_op = cur_bit;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    idx_next   = idx;
    latch      = 1'b0;
    case (state)
      SCAN: begin
        if (|cur) begin
          latch      = 1'b1;
          state_next = OUTPUT;
        end else begin
          idx_next = idx + FLOWID_W'(1);
        end
      end
      OUTPUT: begin
        if (sched_rdy) begin
          idx_next   = idx + FLOWID_W'(1);
          state_next = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  // Dispatch clear lands first so a same-cycle command on the same flow wins.
  always_comb begin
    for (int i = 0; i < MAX_FLOWS; i++) begin
      pend_next[i] = pend[i];
      if (latch && idx == FLOWID_W'(i))
        pend_next[i] = 3'b000;
      if (accept && cmd_flow == FLOWID_W'(i)) begin
        pend_next[i][0] = apply_op(pend_next[i][0], cmd_data.ack_pend_set_clear.cmd);
        pend_next[i][1] = apply_op(pend_next[i][1], cmd_data.data_pend_set_clear.cmd);
        pend_next[i][2] = apply_op(pend_next[i][2], cmd_data.rt_pend_set_clear.cmd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCAN;
      idx      <= '0;
      flowid_q <= '0;
      flags_q  <= '0;
      for (int i = 0; i < MAX_FLOWS; i++)
        pend[i] <= 3'b000;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      for (int i = 0; i < MAX_FLOWS; i++)
        pend[i] <= pend_next[i];
      if (latch) begin
        flowid_q <= idx;
        flags_q  <= cur;
      end
    end
  end

endmodule

// File: tb/tb_tx_pend_sched.sv
// tb/tb_tx_pend_sched.sv - directed and randomized checks of tx_pend_sched against a pending-set model
module tb_tx_pend_sched;
  import tx_pend_sched_pkg::*;

  localparam int NF = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_val;
  sched_cmd_struct cmd_data;
  logic            cmd_rdy;
  logic            sched_val;
  logic [5:0]      sched_flowid;
  logic [2:0]      sched_flags;
  logic            sched_rdy;

  tx_pend_sched #(.MAX_FLOWS(NF)) dut (
    .clk(clk), .rst(rst), .cmd_val(cmd_val), .cmd_data(cmd_data), .cmd_rdy(cmd_rdy),
    .sched_val(sched_val), .sched_flowid(sched_flowid), .sched_flags(sched_flags),
    .sched_rdy(sched_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model: a set of pending bits per flow, a round-robin pointer, and at most one held dispatch.
  bit [2:0] m_pend [NF];
  int       m_ptr;
  bit       m_busy;
  int       m_fl;
  bit [2:0] m_fg;

  int       log_fl [$];
  bit [2:0] log_fg [$];

  function automatic bit [2:0] apply(input bit [2:0] v, input bit [1:0] a, d, t);
    bit [1:0] ops [3];
    ops[0] = a; ops[1] = d; ops[2] = t;
    for (int b = 0; b < 3; b++) begin
      if (ops[b] == 2'd1) v[b] = 1'b1;
      else if (ops[b] == 2'd2) v[b] = 1'b0;
    end
    return v;
  endfunction

  task automatic model_step(input bit r, input bit v, input int fid,
                            input bit [1:0] a, d, t, input bit rdy);
    if (r) begin
      foreach (m_pend[i]) m_pend[i] = 3'b000;
      m_ptr = 0; m_busy = 0; m_fl = 0; m_fg = 3'b000;
      return;
    end
    if (!m_busy) begin
      if (m_pend[m_ptr] != 3'b000) begin
        m_busy = 1; m_fl = m_ptr; m_fg = m_pend[m_ptr]; m_pend[m_ptr] = 3'b000;
      end else begin
        m_ptr = (m_ptr + 1) % NF;
      end
    end else if (rdy) begin
      m_busy = 0;
      m_ptr  = (m_ptr + 1) % NF;
    end
    if (v) m_pend[fid] = apply(m_pend[fid], a, d, t);
  endtask

  task automatic cyc(input bit r, input bit v, input int fid,
                     input bit [1:0] a, d, t, input bit rdy);
    rst      = r;
    cmd_val  = v;
    cmd_data = '0;
    cmd_data.flowid = 16'(fid);
    cmd_data.ack_pend_set_clear.cmd        = a;
    cmd_data.data_pend_set_clear.cmd       = d;
    cmd_data.rt_pend_set_clear.cmd         = t;
    cmd_data.ack_pend_set_clear.timestamp  = 16'($urandom);
    cmd_data.data_pend_set_clear.timestamp = 16'($urandom);
    cmd_data.rt_pend_set_clear.timestamp   = 16'($urandom);
    sched_rdy = rdy;
    #1;
    check("cmd_rdy", cmd_rdy, !r);
    if (!r && sched_val && rdy) begin
      log_fl.push_back(int'(sched_flowid));
      log_fg.push_back(sched_flags);
    end
    @(posedge clk);
    model_step(r, v, fid, a, d, t, rdy);
    @(negedge clk);
    check("sched_val", sched_val, m_busy);
    if (m_busy) begin
      check("sched_flowid", sched_flowid, m_fl);
      check("sched_flags", sched_flags, m_fg);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 2'd0, 2'd0, 2'd0, rdy);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 2'd0, 2'd0, 2'd0, 1);
    cyc(1, 0, 0, 2'd0, 2'd0, 2'd0, 1);
    log_fl.delete();
    log_fg.delete();
  endtask

  initial begin
    int cnt;
    int seen [NF];

    // reset state, then single data dispatch for flow 5
    do_reset();
    check("rst_flowid", sched_flowid, 0);
    check("rst_flags", sched_flags, 0);
    idle(8, 1);
    cyc(0, 1, 5, 2'd0, 2'd1, 2'd0, 1);
    idle(200, 1);
    check("f5_count", log_fl.size(), 1);
    if (log_fl.size() == 1) begin
      check("f5_flowid", log_fl[0], 5);
      check("f5_flags", log_fg[0], 3'b010);
    end

    // flow 3 ack+rt and flow 60 data, dispatched in scan order
    do_reset();
    cyc(0, 1, 3, 2'd1, 2'd0, 2'd1, 1);
    cyc(0, 1, 60, 2'd0, 2'd1, 2'd0, 1);
    idle(200, 1);
    check("f3f60_count", log_fl.size(), 2);
    if (log_fl.size() == 2) begin
      check("f3_flowid", log_fl[0], 3);
      check("f3_flags", log_fg[0], 3'b101);
      check("f60_flowid", log_fl[1], 60);
      check("f60_flags", log_fg[1], 3'b010);
    end

    // backpressure on flow 7, re-set during hold is served later
    do_reset();
    cyc(0, 1, 7, 2'd1, 2'd0, 2'd0, 0);
    idle(12, 0);
    check("f7_held_val", sched_val, 1);
    cyc(0, 1, 7, 2'd0, 2'd1, 2'd0, 0);
    for (int k = 0; k < 19; k++) begin
      cyc(0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
      check("f7_hold_flowid", sched_flowid, 7);
      check("f7_hold_flags", sched_flags, 3'b001);
    end
    idle(150, 1);
    check("f7_count", log_fl.size(), 2);
    if (log_fl.size() == 2) begin
      check("f7_first_flags", log_fg[0], 3'b001);
      check("f7_second_flowid", log_fl[1], 7);
      check("f7_second_flags", log_fg[1], 3'b010);
    end

    // set then clear before the scan arrives
    do_reset();
    cyc(0, 1, 40, 2'd1, 2'd0, 2'd0, 1);
    cyc(0, 1, 40, 2'd2, 2'd0, 2'd0, 1);
    idle(150, 1);
    check("f40_cleared_count", log_fl.size(), 0);

    // every flow pending: each dispatched exactly once
    do_reset();
    for (int f = 0; f < NF; f++) cyc(0, 1, f, 2'd0, 2'd0, 2'd1, 1);
    cnt = 0;
    while (log_fl.size() < NF && cnt < 500) begin
      idle(1, 1);
      cnt++;
    end
    check("all_count", log_fl.size(), NF);
    foreach (seen[i]) seen[i] = 0;
    foreach (log_fl[i]) seen[log_fl[i]]++;
    for (int f = 0; f < NF; f++) check("all_once", seen[f], 1);
    idle(150, 1);
    check("all_no_extra", log_fl.size(), NF);

    // reset while a dispatch is held
    do_reset();
    cyc(0, 1, 9, 2'd0, 2'd1, 2'd0, 0);
    idle(15, 0);
    check("f9_held_val", sched_val, 1);
    cyc(1, 0, 0, 2'd0, 2'd0, 2'd0, 0);
    check("midrst_flowid", sched_flowid, 0);
    check("midrst_flags", sched_flags, 0);
    idle(150, 1);
    check("midrst_no_disp", log_fl.size(), 0);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bit r, v, rdy;
      int fid;
      r   = ($urandom % 300) == 0;
      v   = ($urandom % 3) != 0;
      fid = (($urandom % 8) < 6) ? int'($urandom % 8) : int'($urandom % NF);
      rdy = ($urandom % 4) != 0;
      cyc(r, v, fid, 2'($urandom), 2'($urandom), 2'($urandom), rdy);
    end
    check("rand_dispatched", log_fl.size() > 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
